// File: rtl/mux_arb_pkg.sv
// Shared constants, state type and helpers for the 8-way packet-locked arbiter.
// Build option MUX_ARB_FIXED_PRIO_EN is consumed by rr_pick8 and mux8_rr_arbiter.
package mux_arb_pkg;

  localparam int N_REQ = 8;
  localparam int SEL_W = 3;

  typedef enum logic {IDLE, BUSY} arb_state_t;

  // Input must be one-hot or zero; zero maps to index 0.
  function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] onehot);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (onehot[k]) idx = idx | SEL_W'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mux8.sv
// Plain 8:1 data multiplexer, WIDTH bits per lane; lane k sits at [k*WIDTH +: WIDTH].
module mux8 #(
  parameter int WIDTH = 8
) (
  input  logic [8*WIDTH-1:0] i_data,
  input  logic [2:0]         i_sel,
  output logic [WIDTH-1:0]   o_data
);

  assign o_data = i_data[i_sel*WIDTH +: WIDTH];

endmodule

// File: rtl/rr_pick8.sv
// Rotating first-set-bit search over 8 requests, starting at ptr.
// With MUX_ARB_FIXED_PRIO_EN defined the scan always starts at requester 0.
module rr_pick8
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] w_base;
  logic [N_REQ-1:0] w_rot;
  logic [N_REQ-1:0] w_low;

`ifdef MUX_ARB_FIXED_PRIO_EN
  assign w_base = '0;
`else
  assign w_base = ptr;
`endif

  // NOTE: every bit of w_rot is assigned on every pass, so no latch can be inferred.
  always_comb begin
    w_rot = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_rot[k] = req[SEL_W'(k) + w_base];
    end
  end

  // Isolate the lowest set bit of the rotated vector, then undo the rotation.
  assign w_low = w_rot & (~w_rot + N_REQ'(1));
  assign found = |req;
  assign idx   = onehot_to_idx(w_low) + w_base;

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Packet-locked round-robin arbiter sharing one stream between 8 requesters.
// Define MUX_ARB_FIXED_PRIO_EN for fixed priority (requester 0 highest).
module mux8_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req_i,
  input  logic [N_REQ-1:0]            valid_i,
  input  logic [N_REQ-1:0]            last_i,
  input  logic [N_REQ*DATA_WIDTH-1:0] data_i,
  output logic [N_REQ-1:0]            ready_o,
  output logic [DATA_WIDTH-1:0]       data_o,
  output logic                        valid_o,
  output logic                        last_o,
  input  logic                        ready_i,
  output logic [N_REQ-1:0]            grant_o,
  output logic [SEL_W-1:0]            sel_o,
  output logic                        busy_o
);

  localparam int               CNT_W     = $clog2(MAX_BURST);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  arb_state_t       r_state;
  logic [N_REQ-1:0] r_grant;
  logic [SEL_W-1:0] r_sel;
  logic [SEL_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_beat_cnt;

  logic             w_found;
  logic [SEL_W-1:0] w_pick_idx;
  logic             w_busy;
  logic             w_live;
  logic             w_xfer;
  logic             w_release;

  rr_pick8 u_pick (
    .req   (req_i),
    .ptr   (r_ptr),
    .found (w_found),
    .idx   (w_pick_idx)
  );

  mux8 #(.WIDTH(DATA_WIDTH)) u_mux (
    .i_data (data_i),
    .i_sel  (r_sel),
    .o_data (data_o)
  );

  assign w_busy = (r_state == BUSY);
  // Reset kills the handshake in the same cycle so no beat slips through.
  assign w_live = w_busy & ~rst;

  assign valid_o = w_live & valid_i[r_sel];
  assign last_o  = w_live & last_i[r_sel];
  assign ready_o = (w_live & ready_i) ? r_grant : '0;

  assign w_xfer    = w_busy & valid_i[r_sel] & ready_i;
  assign w_release = w_busy & ((w_xfer & (last_i[r_sel] | (r_beat_cnt == LAST_BEAT)))
                             | (~w_xfer & ~req_i[r_sel]));

  assign grant_o = r_grant;
  assign sel_o   = r_sel;
  assign busy_o  = w_busy;

  // NOTE: all state updates use <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_grant    <= '0;
      r_sel      <= '0;
      r_ptr      <= '0;
      r_beat_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_state    <= BUSY;
            r_grant    <= N_REQ'(1) << w_pick_idx;
            r_sel      <= w_pick_idx;
            r_beat_cnt <= '0;
          end
        end
        BUSY: begin
          if (w_release) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_beat_cnt <= '0;
`ifdef MUX_ARB_FIXED_PRIO_EN
            r_ptr      <= '0;
`else
            r_ptr      <= r_sel + SEL_W'(1);
`endif
          end else if (w_xfer) begin
            r_beat_cnt <= r_beat_cnt + CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mux8_rr_arbiter.md
Name: mux8_rr_arbiter

Overview:
- Round-robin arbiter that shares one DATA_WIDTH output stream between 8 requesters.
- Drives the select of an 8:1 datapath mux and gates valid/ready per requester.
- Grants are packet-locked: held until the last beat, the burst limit, or the requester dropping its request.
- Sits between 8 producer streams and a single consumer.

Parameters:
- DATA_WIDTH, 8, width of each data channel.
- MAX_BURST, 16, maximum beats per grant before forced release; legal range >=2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- req_i  input  8  per-requester request.
- valid_i  input  8  per-requester beat valid.
- last_i  input  8  per-requester last-beat flag.
- data_i  input  8*DATA_WIDTH  requester k on bits [k*DATA_WIDTH +: DATA_WIDTH].
- ready_o  output  8  per-requester ready.
- data_o  output  DATA_WIDTH  muxed data.
- valid_o  output  1  muxed valid.
- last_o  output  1  muxed last.
- ready_i  input  1  consumer ready.
- grant_o  output  8  one-hot current grant; 0 when idle.
- sel_o  output  3  binary index of the granted requester.
- busy_o  output  1  high in the BUSY state.

Behaviour:
- Reset:
  - Synchronous, active-high, single clock domain (clk).
  - On rst: state=IDLE, grant_o=0, sel_o=0, busy_o=0, ptr=0, beat_cnt=0.
  - Because grant is 0: valid_o=0, ready_o=0, last_o=0.
  - data_o follows the mux at sel_o=0 and is don't-care.
  - rst mid-packet aborts the grant immediately; no beat transfers in the reset cycle.
- States: IDLE, BUSY.
- IDLE:
  - If req_i!=0, choose the first set bit scanning ptr, ptr+1, ... modulo 8.
  - Next cycle: grant_o=onehot(g), sel_o=g, state=BUSY, beat_cnt=0.
  - Latency from request to grant is exactly 1 cycle.
  - If req_i==0, stay in IDLE.
- BUSY, combinational gating for granted index g:
  - valid_o = valid_i[g]; last_o = last_i[g]; data_o = data_i[g].
  - ready_o[g] = ready_i; ready_o[k] = 0 for all k!=g.
- Transfer: a beat transfers when valid_i[g] & ready_i; beat_cnt increments on each transfer.
- Release causes, checked in priority order:
  - (a) transfer with last_i[g]=1;
  - (b) transfer with beat_cnt==MAX_BURST-1, i.e. forced release, last not required;
  - (c) req_i[g]=0 with no transfer in that cycle, i.e. abort.
- On release:
  - Next cycle: state=IDLE, grant_o=0, ptr=(g+1) mod 8 with wrap 7->0, beat_cnt=0.
  - There is a 1-cycle IDLE bubble between consecutive grants.
- Other rules:
  - req_i of non-granted requesters is ignored while BUSY.
  - valid_i from a non-granted requester never reaches the output.
  - A transfer and a req_i[g] drop in the same cycle: the transfer completes; release only if (a) or (b) holds, otherwise the next cycle is evaluated again.
  - beat_cnt width is $clog2(MAX_BURST) and never exceeds MAX_BURST-1.

Optional Feature:
- Macro: MUX_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, requester 0 highest. ptr is held at 0 and never updated. The burst limit and abort rules are unchanged.
- Undefined: round-robin as above.

Decomposition:
- Package mux_arb_pkg:
  - N_REQ=8 and SEL_W=3 constants.
  - typedef enum logic {IDLE, BUSY} arb_state_t.
  - function onehot_to_idx.
- Sub-module rr_pick8:
  - Combinational; inputs req[7:0] and ptr[2:0]; outputs found and idx[2:0].
  - Implements the rotating scan; when MUX_ARB_FIXED_PRIO_EN is defined, ptr is tied to 0.
- Datapath: instantiate the team's existing mux8 with sel=sel_o; valid and last use bit indexing.

Test Plan:
- Reset, then req_i=8'b0000_0100 and a 3-beat packet on requester 2 -> grant_o=8'h04 one cycle after request, sel_o=2, 3 transfers, last_o on beat 3, grant_o=0 on the next cycle, ptr=3.
- All req_i=8'hFF, 1-beat packets each -> grant order 0,1,...,7,0 with one idle cycle between grants; ptr wraps 7->0.
- Requester 5 sends 20 beats without last, ready_i=1 -> forced release after beat 16, ready_o[5]=0 in the next cycle, re-grant later for the remaining 4 beats.
- ready_i toggling 1,0,1,0 during a 4-beat packet on requester 1 -> exactly 4 transfers; data_o stable while valid_o=1 and ready_i=0; no beat lost.
- Requester 6 granted, drops req_i with valid_i=0 -> abort: IDLE next cycle, ptr=7. Separately, rst asserted mid-packet -> all outputs at reset values next cycle.
- MUX_ARB_FIXED_PRIO_EN defined, req_i=8'hFF continuously with 1-beat packets -> requester 0 granted every grant cycle; requesters 1-7 are never granted.
